// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - note codes and tone timing helpers shared by the playback datapath
// Contents:
//   NOTE_W, NOTE_REST, NOTE_C4..NOTE_B4  note code width and named codes
//   is_pitched(code)                     1 for C4..B4 (1..12), 0 for rests (0, 13..15)
//   half_period(code, clk_hz)            clock cycles per half wave, rounded; 0 for rests
package music_pkg;

    localparam int NOTE_W = 4;

    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_CS4  = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_DS4  = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_FS4  = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_GS4  = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_AS4  = 4'd11;
    localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd12;

    function automatic logic is_pitched(input logic [NOTE_W-1:0] code);
        return (code >= NOTE_C4) && (code <= NOTE_B4);
    endfunction

    // Equal temperament anchored on A4 = 440 Hz exactly (C4 is about 261.63 Hz),
    // frequencies held in micro-hertz so the rounding stays in integer arithmetic.
    // Only ever called with constant arguments, so it folds into a ROM.
    function automatic logic [16:0] half_period(input logic [NOTE_W-1:0] code,
                                                input longint clk_hz);
        longint f_uhz;
        case (code)
            NOTE_C4:  f_uhz = 64'sd261_625_565;
            NOTE_CS4: f_uhz = 64'sd277_182_631;
            NOTE_D4:  f_uhz = 64'sd293_664_768;
            NOTE_DS4: f_uhz = 64'sd311_126_984;
            NOTE_E4:  f_uhz = 64'sd329_627_557;
            NOTE_F4:  f_uhz = 64'sd349_228_231;
            NOTE_FS4: f_uhz = 64'sd369_994_423;
            NOTE_G4:  f_uhz = 64'sd391_995_436;
            NOTE_GS4: f_uhz = 64'sd415_304_698;
            NOTE_A4:  f_uhz = 64'sd440_000_000;
            NOTE_AS4: f_uhz = 64'sd466_163_762;
            NOTE_B4:  f_uhz = 64'sd493_883_301;
            default:  f_uhz = 64'sd0;
        endcase
        if (f_uhz == 64'sd0) begin
            return '0;
        end
        // round(clk_hz / (2 f)) = (clk_hz*1e6 + f_uhz) / (2 f_uhz)
        return 17'((clk_hz * 64'sd1_000_000 + f_uhz) / (64'sd2 * f_uhz));
    endfunction

endpackage

// File: rtl/note_playback_datapath_tone_gen.sv
// rtl/note_playback_datapath_tone_gen.sv - square-wave tone generator driven by the current note
// Ports:
//   clk, reset    system clock, synchronous active-low reset
//   note          registered note code to sound
//   tone_active   1 while note is pitched
//   audio_out     registered signed sample: +AMPL, -AMPL or 0, one cycle after note
module tone_gen
    import music_pkg::*;
#(
    parameter int                 CLK_HZ = 50_000_000,
    parameter logic signed [23:0] AMPL   = 24'sd4194304
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NOTE_W-1:0]        note,
    output logic                     tone_active,
    output logic signed [23:0]       audio_out
);

    logic [16:0]       hp_rom [1<<NOTE_W];
    logic [16:0]       hp;
    logic [NOTE_W-1:0] prev_note;
    logic [16:0]       cnt;
    logic [16:0]       cnt_n;
    logic              phase;
    logic              phase_n;

    for (genvar g = 0; g < (1 << NOTE_W); g++) begin : g_rom
        localparam logic [16:0] HP = half_period(NOTE_W'(g), longint'(CLK_HZ));
        assign hp_rom[g] = HP;
    end

    assign hp          = hp_rom[note];
    assign tone_active = is_pitched(note);

    // A new code restarts on the positive half; a repeated code across slot
    // boundaries keeps counting so the waveform stays continuous. Rests park at 0.
    always_comb begin
        cnt_n   = '0;
        phase_n = 1'b0;
        if (tone_active) begin
            if (note != prev_note) begin
                cnt_n   = hp - 17'd1;
                phase_n = 1'b0;
            end else if (cnt == '0) begin
                cnt_n   = hp - 17'd1;
                phase_n = ~phase;
            end else begin
                cnt_n   = cnt - 17'd1;
                phase_n = phase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_note <= NOTE_REST;
            cnt       <= '0;
            phase     <= 1'b0;
            audio_out <= '0;
        end else begin
            prev_note <= note;
            cnt       <= cnt_n;
            phase     <= phase_n;
            // Uses the updated phase so the first sample of a new note is +AMPL.
            audio_out <= tone_active ? (phase_n ? -AMPL : AMPL) : '0;
        end
    end

endmodule

// File: rtl/note_playback_datapath.sv
// rtl/note_playback_datapath.sv - note register file, write control and playback read path
// Ports:
//   clk, reset     system clock, synchronous active-low reset
//   note_in        note code to store
//   ld_note        load level; one write per rising edge, ignored during playback
//   ld_play        playback level
//   note_counter   playback slot index
//   wr_ptr         next slot to be written
//   mem_full       sticky, set once every slot has been written
//   cur_note       registered note being played (rest when not playing)
//   tone_active    cur_note is pitched
//   audio_out      signed square-wave sample
module note_playback_datapath
    import music_pkg::*;
#(
    parameter int                 CLK_HZ = 50_000_000,
    parameter int                 DEPTH  = 16,
    parameter logic signed [23:0] AMPL   = 24'sd4194304
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NOTE_W-1:0]        note_in,
    input  logic                     ld_note,
    input  logic                     ld_play,
    input  logic [NOTE_W-1:0]        note_counter,
    output logic [NOTE_W-1:0]        wr_ptr,
    output logic                     mem_full,
    output logic [NOTE_W-1:0]        cur_note,
    output logic                     tone_active,
    output logic signed [23:0]       audio_out
);

    logic [NOTE_W-1:0] mem [DEPTH];
    logic              ld_note_d;
    logic              wr_en;

    // ld_note_d tracks ld_note even during play, so an edge that lands while
    // playing is consumed and never turns into a late write.
    assign wr_en = ld_note & ~ld_note_d & ~ld_play;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= NOTE_REST;
            end
            wr_ptr    <= '0;
            mem_full  <= 1'b0;
            ld_note_d <= 1'b0;
            cur_note  <= NOTE_REST;
        end else begin
            ld_note_d <= ld_note;
            if (wr_en) begin
                mem[wr_ptr] <= note_in;
                wr_ptr      <= wr_ptr + 1'b1;
                if (wr_ptr == NOTE_W'(DEPTH - 1)) begin
                    mem_full <= 1'b1;
                end
            end
            cur_note <= ld_play ? mem[note_counter] : NOTE_REST;
        end
    end

    tone_gen #(
        .CLK_HZ (CLK_HZ),
        .AMPL   (AMPL)
    ) u_tone_gen (
        .clk         (clk),
        .reset       (reset),
        .note        (cur_note),
        .tone_active (tone_active),
        .audio_out   (audio_out)
    );

endmodule

// File: tb/tb_note_playback_datapath.sv
// tb/tb_note_playback_datapath.sv - self-checking bench for note_playback_datapath
module tb_note_playback_datapath;
    import music_pkg::*;

    localparam int                 CLK_HZ = 500_000;
    localparam logic signed [23:0] AMPL   = 24'sd4194304;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  note_in = '0;
    logic        ld_note = 1'b0;
    logic        ld_play = 1'b0;
    logic [3:0]  note_counter = '0;
    logic [3:0]  wr_ptr;
    logic        mem_full;
    logic [3:0]  cur_note;
    logic        tone_active;
    logic signed [23:0] audio_out;

    note_playback_datapath #(
        .CLK_HZ (CLK_HZ),
        .DEPTH  (16),
        .AMPL   (AMPL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .note_in      (note_in),
        .ld_note      (ld_note),
        .ld_play      (ld_play),
        .note_counter (note_counter),
        .wr_ptr       (wr_ptr),
        .mem_full     (mem_full),
        .cur_note     (cur_note),
        .tone_active  (tone_active),
        .audio_out    (audio_out)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int mem_m [16];
    int wp_m, full_m, cur_m, seg_start, prev_ld, cyc;
    logic signed [23:0] aud_m;

    function automatic int hp_model(input int code, input real clk_hz);
        real f;
        if (code < 1 || code > 12) return 0;
        f = 440.0 * (2.0 ** ((code - 10) / 12.0));
        return $rtoi(clk_hz / (2.0 * f) + 0.5);
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int code;
        int k;
        @(posedge clk);
        cyc++;
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem_m[i] = 0;
            wp_m = 0; full_m = 0; cur_m = 0; prev_ld = 0; seg_start = 0;
            aud_m = '0;
        end else begin
            // sample reflects the note held during the previous cycle
            if (cur_m >= 1 && cur_m <= 12) begin
                k = (cyc - 1) - seg_start;
                aud_m = (((k / hp_model(cur_m, real'(CLK_HZ))) % 2) == 0) ? AMPL : -AMPL;
            end else begin
                aud_m = '0;
            end
            code = ld_play ? mem_m[note_counter] : 0;
            if (code != cur_m) seg_start = cyc;
            cur_m = code;
            if (ld_note && !prev_ld && !ld_play) begin
                mem_m[wp_m] = note_in;
                if (wp_m == 15) full_m = 1;
                wp_m = (wp_m + 1) % 16;
            end
            prev_ld = ld_note;
        end
        #1;
        check("wr_ptr", wr_ptr, wp_m);
        check("mem_full", mem_full, full_m);
        check("cur_note", cur_note, cur_m);
        check("tone_active", tone_active, (cur_m >= 1 && cur_m <= 12) ? 1 : 0);
        check("audio_out", audio_out, aud_m);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input int v);
        note_in = 4'(v);
        ld_note = 1'b1;
        tick();
        ld_note = 1'b0;
        tick();
    endtask

    task automatic play(input int slot, input int n);
        ld_play = 1'b1;
        note_counter = 4'(slot);
        run(n);
    endtask

    initial begin
        int vals [16];
        int v;
        cyc = 0;
        for (int i = 0; i < 16; i++) vals[i] = (i < 12) ? i + 1 : ((i == 12) ? 0 : i - 12);

        // reset
        reset = 1'b0;
        run(3);
        check("reset_audio", audio_out, 0);
        check("reset_wr_ptr", wr_ptr, 0);
        reset = 1'b1;
        run(2);

        // fill all 16 slots
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("not_full_before_16th", mem_full, 0);
            wr(vals[i]);
        end
        check("wr_ptr_wrapped", wr_ptr, 0);
        check("full_after_16", mem_full, 1);

        // 17th write overwrites slot 0
        wr(5);
        check("wr_ptr_after_17th", wr_ptr, 1);
        check("full_sticky", mem_full, 1);

        // held ld_note writes once
        note_in = 4'($urandom_range(0, 15));
        ld_note = 1'b1;
        run(10);
        ld_note = 1'b0;
        run(1);
        check("hold_one_write", wr_ptr, 2);
        wr(14);

        // half-period table at the production clock
        for (int c = 0; c < 16; c++)
            check("hp_50mhz", half_period(4'(c), 64'sd50_000_000), hp_model(c, 50.0e6));
        check("hp_a4_50mhz", half_period(NOTE_A4, 64'sd50_000_000), 56818);

        // A4 playback, several half periods
        ld_play = 1'b1;
        note_counter = 4'd9;
        tick();
        check("a4_latency", cur_note, 10);
        run(3 * hp_model(10, real'(CLK_HZ)) + 10);

        // rests and same-code continuity (slots 0 and 4 both hold 5)
        play(2, 40);
        check("rest14_audio", audio_out, 0);
        play(12, 40);
        check("rest0_active", tone_active, 0);
        play(0, 700);
        play(4, 700);
        play(9, 200);
        ld_play = 1'b0;
        run(3);
        check("end_play_audio", audio_out, 0);

        // ld_note edge during play is dropped
        play(9, 5);
        note_in = 4'd7;
        ld_note = 1'b1;
        run(3);
        ld_play = 1'b0;
        run(3);
        ld_note = 1'b0;
        run(1);
        check("no_write_in_play", wr_ptr, 3);

        // random writes and playback
        repeat (25) begin
            v = $urandom_range(0, 2);
            if (v == 0) begin
                wr($urandom_range(0, 15));
            end else if (v == 1) begin
                play($urandom_range(0, 15), $urandom_range(1, 1200));
            end else begin
                ld_play = 1'b0;
                ld_note = $urandom_range(0, 1) == 1;
                note_in = 4'($urandom_range(0, 15));
                run($urandom_range(1, 5));
                ld_note = 1'b0;
            end
        end

        // reset in the middle of a tone
        play(9, 300);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midreset_audio", audio_out, 0);
        check("midreset_cur", cur_note, 0);
        check("midreset_wr_ptr", wr_ptr, 0);
        for (int s = 0; s < 16; s++) play(s, 2);
        ld_play = 1'b0;
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
